// File: rtl/pci_target_ctrl.sv
// PCI target command/handshake controller: latches the bus command at the address
// phase and issues storage read/write enables on each completed data phase.
module pci_target_ctrl #(
   parameter logic [3:0] CMD_READ  = 4'b0110,
   parameter logic [3:0] CMD_WRITE = 4'b0111
) (
   input  logic       Clock,
   input  logic       ResetN,
   input  logic       Frame,
   input  logic       Irdy,
   input  logic       Devsel,
   input  logic [3:0] CBE,
   output logic [1:0] Rw,
   output logic       RE,
   output logic       WE
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DATA = 1'b1;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   logic [0:0] state_q, state_d;
   logic [1:0] rw_q, rw_d;
   logic       frame_q, frame_d;
   logic       addr_phase;
   logic       xfer;

   // frame_q resets low so a Frame already asserted at reset release is not an address phase
   assign addr_phase = frame_q & ~Frame;
   assign frame_d    = Frame;

   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      case (state_q)
         ST_IDLE: begin
            if (addr_phase) begin
               state_d = ST_DATA;
               if (CBE == CMD_READ)
                  rw_d = RW_READ;
               else if (CBE == CMD_WRITE)
                  rw_d = RW_WRITE;
               else
                  rw_d = RW_NONE;
            end
         end
         ST_DATA: begin
            if (Frame) begin
               state_d = ST_IDLE;
               rw_d    = RW_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rw_d    = RW_NONE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= ST_IDLE;
         rw_q    <= RW_NONE;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         frame_q <= frame_d;
      end
   end

   // Zero-latency enables: storage consumes the transfer on the same edge
   assign xfer = (state_q == ST_DATA) & ~Devsel & ~Irdy;
   assign RE   = xfer & (rw_q == RW_READ);
   assign WE   = xfer & (rw_q == RW_WRITE);
   assign Rw   = rw_q;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Bench for pci_target_ctrl: directed vector table, reset corner sequence, and
// randomized traffic checked against a transaction-level reference model.
module tb_pci_target_ctrl;

   localparam logic [3:0] RD = 4'b0110;
   localparam logic [3:0] WR = 4'b0111;

   logic       Clock = 1'b0;
   logic       ResetN;
   logic       Frame, Irdy, Devsel;
   logic [3:0] CBE;
   logic [1:0] Rw;
   logic       RE, WE;

   int checks = 0;
   int errors = 0;

   pci_target_ctrl #(.CMD_READ(RD), .CMD_WRITE(WR)) dut (
      .Clock (Clock),
      .ResetN(ResetN),
      .Frame (Frame),
      .Irdy  (Irdy),
      .Devsel(Devsel),
      .CBE   (CBE),
      .Rw    (Rw),
      .RE    (RE),
      .WE    (WE)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end

   // Reference model: a transaction is either open or not, with a command kind
   typedef enum int {K_NONE, K_READ, K_WRITE} kind_e;
   bit    m_open;
   kind_e m_kind;
   bit    m_prev_frame;

   function automatic void model_reset();
      m_open       = 0;
      m_kind       = K_NONE;
      m_prev_frame = 0;
   endfunction

   function automatic void model_edge(input logic f, input logic [3:0] c);
      if (m_open) begin
         if (f) m_open = 0;
      end else if (m_prev_frame && !f) begin
         m_open = 1;
         m_kind = (c == RD) ? K_READ : (c == WR) ? K_WRITE : K_NONE;
      end
      m_prev_frame = f;
   endfunction

   function automatic logic [1:0] model_rw();
      if (!m_open) return 2'b00;
      return (m_kind == K_READ) ? 2'b01 : (m_kind == K_WRITE) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic model_re(input logic i, input logic d);
      return m_open && m_kind == K_READ && !i && !d;
   endfunction

   function automatic logic model_we(input logic i, input logic d);
      return m_open && m_kind == K_WRITE && !i && !d;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, compare mid-cycle, then advance the model at the edge
   task automatic step(input logic f, input logic i, input logic d, input logic [3:0] c,
                       input bit use_tbl, input logic [1:0] erw, input logic ere,
                       input logic ewe, input string tag);
      logic [1:0] xrw;
      logic       xre, xwe;
      Frame = f; Irdy = i; Devsel = d; CBE = c;
      @(negedge Clock);
      if (use_tbl) begin
         xrw = erw; xre = ere; xwe = ewe;
      end else begin
         xrw = model_rw(); xre = model_re(i, d); xwe = model_we(i, d);
      end
      chk({tag, ".rw"}, {2'b00, Rw}, {2'b00, xrw});
      chk({tag, ".re"}, {3'b000, RE}, {3'b000, xre});
      chk({tag, ".we"}, {3'b000, WE}, {3'b000, xwe});
      @(posedge Clock);
      model_edge(f, c);
      #1;
   endtask

   typedef struct {
      logic       f, i, d;
      logic [3:0] c;
      logic [1:0] rw;
      logic       re, we;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic f, input logic i, input logic d, input logic [3:0] c,
                               input logic [1:0] rw, input logic re, input logic we);
      vec_t v;
      v.f = f; v.i = i; v.d = d; v.c = c; v.rw = rw; v.re = re; v.we = we;
      tbl.push_back(v);
   endfunction

   initial begin
      // idle
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);
      // write burst, 3 data phases
      add(0, 1, 1, WR,   2'b00, 0, 0);
      add(0, 0, 0, 4'hF, 2'b10, 0, 1);
      add(0, 0, 0, 4'hF, 2'b10, 0, 1);
      add(1, 0, 0, 4'hF, 2'b10, 0, 1);
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);
      // read burst, 4 data phases
      add(0, 1, 1, RD,   2'b00, 0, 0);
      add(0, 0, 0, 4'hF, 2'b01, 1, 0);
      add(0, 0, 0, 4'hF, 2'b01, 1, 0);
      add(0, 0, 0, 4'hF, 2'b01, 1, 0);
      add(1, 0, 0, 4'hF, 2'b01, 1, 0);
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);
      // write with initiator wait state in 2nd data cycle
      add(0, 1, 1, WR,   2'b00, 0, 0);
      add(0, 0, 0, 4'hF, 2'b10, 0, 1);
      add(0, 1, 0, 4'hF, 2'b10, 0, 0);
      add(0, 0, 0, 4'hF, 2'b10, 0, 1);
      add(1, 0, 0, 4'hF, 2'b10, 0, 1);
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);
      // unsupported command
      add(0, 1, 1, 4'h2, 2'b00, 0, 0);
      add(0, 0, 0, 4'hF, 2'b00, 0, 0);
      add(0, 0, 0, 4'hF, 2'b00, 0, 0);
      add(1, 0, 0, 4'hF, 2'b00, 0, 0);
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);
      // write not claimed by devsel
      add(0, 1, 1, WR,   2'b00, 0, 0);
      add(0, 0, 1, 4'hF, 2'b10, 0, 0);
      add(0, 0, 1, 4'hF, 2'b10, 0, 0);
      add(1, 0, 1, 4'hF, 2'b10, 0, 0);
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);
      // byte enables equal to read code during a write; then back-to-back read
      add(0, 1, 1, WR,   2'b00, 0, 0);
      add(0, 0, 0, RD,   2'b10, 0, 1);
      add(1, 0, 0, RD,   2'b10, 0, 1);
      add(0, 1, 1, RD,   2'b00, 0, 0);
      add(1, 0, 0, 4'hF, 2'b01, 1, 0);
      add(1, 1, 1, 4'h0, 2'b00, 0, 0);

      ResetN = 1'b0; Frame = 1'b1; Irdy = 1'b1; Devsel = 1'b1; CBE = 4'h0;
      model_reset();
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      chk("reset.rw", {2'b00, Rw}, 4'h0);
      chk("reset.re", {3'b000, RE}, 4'h0);
      chk("reset.we", {3'b000, WE}, 4'h0);
      @(posedge Clock);
      #1 ResetN = 1'b1;

      foreach (tbl[k])
         step(tbl[k].f, tbl[k].i, tbl[k].d, tbl[k].c, 1,
              tbl[k].rw, tbl[k].re, tbl[k].we, $sformatf("vec%0d", k));

      // Reset in the middle of a write burst, Frame kept low afterwards
      step(0, 1, 1, WR,   1, 2'b00, 0, 0, "rst.addr");
      step(0, 0, 0, 4'hF, 1, 2'b10, 0, 1, "rst.data");
      Frame = 0; Irdy = 0; Devsel = 0; CBE = 4'hF;
      #1 ResetN = 1'b0;
      #1;
      chk("rst.async.rw", {2'b00, Rw}, 4'h0);
      chk("rst.async.we", {3'b000, WE}, 4'h0);
      model_reset();
      #1 ResetN = 1'b1;
      @(posedge Clock); #1;
      for (int n = 0; n < 3; n++)
         step(0, 0, 0, WR, 1, 2'b00, 0, 0, "rst.hold");
      step(1, 1, 1, 4'h0, 1, 2'b00, 0, 0, "rst.rise");
      step(0, 1, 1, WR,   1, 2'b00, 0, 0, "rst.readdr");
      step(0, 0, 0, 4'hF, 1, 2'b10, 0, 1, "rst.redata");
      step(1, 0, 0, 4'hF, 1, 2'b10, 0, 1, "rst.relast");
      step(1, 1, 1, 4'h0, 1, 2'b00, 0, 0, "rst.idle");

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         logic       f, i, d;
         logic [3:0] c;
         f = ($urandom_range(0, 3) == 0);
         i = ($urandom_range(0, 3) == 0);
         d = ($urandom_range(0, 4) == 0);
         case ($urandom_range(0, 3))
            0:       c = RD;
            1:       c = WR;
            2:       c = 4'h2;
            default: c = 4'($urandom);
         endcase
         if ($urandom_range(0, 63) == 0) begin
            ResetN = 1'b0;
            #1 ResetN = 1'b1;
            model_reset();
         end
         step(f, i, d, c, 0, 2'b00, 0, 0, $sformatf("rnd%0d", n));
         chk("rnd.excl", {3'b000, RE & WE}, 4'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
